// File: rtl/decode_stage_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : decode_stage_reg                                             |
// | Description : Pipelined decode stage. Register file, control decode and    |
// |               immediate extend feed a registered ID/EX boundary with valid |
// |               tracking, load-use hazard stall and branch flush.            |
// | Option      : DECODE_BYPASS_EN - rising-edge register-file write with a    |
// |               combinational W->D bypass instead of a falling-edge write.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module decode_stage_reg #(
  parameter  int XLEN   = 32,
  parameter  int NREGS  = 32,
  localparam int RIDX_W = $clog2(NREGS)
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic [31:0]       instrD,
  input  logic [XLEN-1:0]   pcD,
  input  logic              validD,
  input  logic              flushE,
  input  logic              regwriteW,
  input  logic [RIDX_W-1:0] rdW,
  input  logic [XLEN-1:0]   resultW,
  output logic              stallFD,
  output logic              validE,
  output logic              regwriteE,
  output logic              memwriteE,
  output logic              branchE,
  output logic              jumpE,
  output logic              jalrE,
  output logic              alusrcE,
  output logic [1:0]        resultsrcE,
  output logic [3:0]        alucontrolE,
  output logic [2:0]        addrmodeE,
  output logic [XLEN-1:0]   rd1E,
  output logic [XLEN-1:0]   rd2E,
  output logic [XLEN-1:0]   extimmE,
  output logic [XLEN-1:0]   pcE,
  output logic [RIDX_W-1:0] rs1E,
  output logic [RIDX_W-1:0] rs2E,
  output logic [RIDX_W-1:0] rdE
);

  // Opcodes
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;

  // ALU operation encoding seen by Execute
  localparam logic [3:0] c_ALU_ADD  = 4'd0;
  localparam logic [3:0] c_ALU_SUB  = 4'd1;
  localparam logic [3:0] c_ALU_AND  = 4'd2;
  localparam logic [3:0] c_ALU_OR   = 4'd3;
  localparam logic [3:0] c_ALU_XOR  = 4'd4;
  localparam logic [3:0] c_ALU_SLT  = 4'd5;
  localparam logic [3:0] c_ALU_SLTU = 4'd6;
  localparam logic [3:0] c_ALU_SLL  = 4'd7;
  localparam logic [3:0] c_ALU_SRL  = 4'd8;
  localparam logic [3:0] c_ALU_SRA  = 4'd9;
  localparam logic [3:0] c_ALU_PASSB = 4'd10;

  // Immediate formats
  localparam logic [2:0] c_IMM_I = 3'd0;
  localparam logic [2:0] c_IMM_S = 3'd1;
  localparam logic [2:0] c_IMM_B = 3'd2;
  localparam logic [2:0] c_IMM_J = 3'd3;
  localparam logic [2:0] c_IMM_U = 3'd4;

  logic [6:0]        w_opcode;
  logic [2:0]        w_funct3;
  logic              w_f7b5;
  logic [4:0]        w_rs1f, w_rs2f, w_rdf;
  logic [RIDX_W-1:0] w_rs1D, w_rs2D, w_rdD;

  assign w_opcode = instrD[6:0];
  assign w_funct3 = instrD[14:12];
  assign w_f7b5   = instrD[30];
  assign w_rs1f   = instrD[19:15];
  assign w_rs2f   = instrD[24:20];
  assign w_rdf    = instrD[11:7];

  // Out-of-range indices collapse to x0 so reads return 0 and writes vanish.
  generate
    if (RIDX_W < 5) begin : g_idx_narrow
      assign w_rs1D = (w_rs1f[4:RIDX_W] == '0) ? w_rs1f[RIDX_W-1:0] : '0;
      assign w_rs2D = (w_rs2f[4:RIDX_W] == '0) ? w_rs2f[RIDX_W-1:0] : '0;
      assign w_rdD  = (w_rdf[4:RIDX_W]  == '0) ? w_rdf[RIDX_W-1:0]  : '0;
    end else begin : g_idx_wide
      assign w_rs1D = RIDX_W'(w_rs1f);
      assign w_rs2D = RIDX_W'(w_rs2f);
      assign w_rdD  = RIDX_W'(w_rdf);
    end
  endgenerate

  // ---------------------------------------------------------------- regfile
  logic [XLEN-1:0] r_rf [NREGS];
  logic [XLEN-1:0] w_rd1, w_rd2;

`ifdef DECODE_BYPASS_EN
  // Rising-edge write; the bypass below makes same-cycle W->D visible.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
    end else if (regwriteW && rdW != '0) begin
      r_rf[rdW] <= resultW;
    end
  end

  assign w_rd1 = (w_rs1D == '0) ? '0 :
                 (regwriteW && rdW == w_rs1D) ? resultW : r_rf[w_rs1D];
  assign w_rd2 = (w_rs2D == '0) ? '0 :
                 (regwriteW && rdW == w_rs2D) ? resultW : r_rf[w_rs2D];
`else
  // Falling-edge write so the second half-cycle reads the freshly written value.
  always_ff @(negedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
    end else if (regwriteW && rdW != '0) begin
      r_rf[rdW] <= resultW;
    end
  end

  assign w_rd1 = (w_rs1D == '0) ? '0 : r_rf[w_rs1D];
  assign w_rd2 = (w_rs2D == '0) ? '0 : r_rf[w_rs2D];
`endif

  // ----------------------------------------------------------- control unit
  logic       w_regwrite, w_memwrite, w_branch, w_jump, w_jalr, w_alusrc;
  logic [1:0] w_resultsrc;
  logic [3:0] w_aluctl;
  logic [2:0] w_addrmode;
  logic [2:0] w_immsrc;
  logic [3:0] w_aluop_f3;

  // ALU function from funct3; bit 30 selects sub/sra where it applies.
  always_comb begin
    w_aluop_f3 = c_ALU_ADD;
    case (w_funct3)
      3'b000: w_aluop_f3 = (w_opcode == c_OP_RTYPE && w_f7b5) ? c_ALU_SUB : c_ALU_ADD;
      3'b001: w_aluop_f3 = c_ALU_SLL;
      3'b010: w_aluop_f3 = c_ALU_SLT;
      3'b011: w_aluop_f3 = c_ALU_SLTU;
      3'b100: w_aluop_f3 = c_ALU_XOR;
      3'b101: w_aluop_f3 = w_f7b5 ? c_ALU_SRA : c_ALU_SRL;
      3'b110: w_aluop_f3 = c_ALU_OR;
      default: w_aluop_f3 = c_ALU_AND;
    endcase
  end

  // Main decoder: opcode to datapath controls; unknown opcodes decode as no-ops.
  always_comb begin
    w_regwrite  = 1'b0;
    w_memwrite  = 1'b0;
    w_branch    = 1'b0;
    w_jump      = 1'b0;
    w_jalr      = 1'b0;
    w_alusrc    = 1'b0;
    w_resultsrc = 2'b00;
    w_aluctl    = c_ALU_ADD;
    w_addrmode  = 3'b000;
    w_immsrc    = c_IMM_I;
    case (w_opcode)
      c_OP_LOAD: begin
        w_regwrite  = 1'b1;
        w_alusrc    = 1'b1;
        w_resultsrc = 2'b01;
        w_addrmode  = w_funct3;
      end
      c_OP_STORE: begin
        w_memwrite  = 1'b1;
        w_alusrc    = 1'b1;
        w_immsrc    = c_IMM_S;
        w_addrmode  = w_funct3;
      end
      c_OP_RTYPE: begin
        w_regwrite  = 1'b1;
        w_aluctl    = w_aluop_f3;
      end
      c_OP_ITYPE: begin
        w_regwrite  = 1'b1;
        w_alusrc    = 1'b1;
        w_aluctl    = w_aluop_f3;
      end
      c_OP_BRANCH: begin
        w_branch    = 1'b1;
        w_aluctl    = c_ALU_SUB;
        w_immsrc    = c_IMM_B;
        w_addrmode  = w_funct3;
      end
      c_OP_JAL: begin
        w_regwrite  = 1'b1;
        w_jump      = 1'b1;
        w_resultsrc = 2'b10;
        w_immsrc    = c_IMM_J;
      end
      c_OP_JALR: begin
        w_regwrite  = 1'b1;
        w_jump      = 1'b1;
        w_jalr      = 1'b1;
        w_alusrc    = 1'b1;
        w_resultsrc = 2'b10;
      end
      c_OP_LUI: begin
        w_regwrite  = 1'b1;
        w_alusrc    = 1'b1;
        w_aluctl    = c_ALU_PASSB;
        w_immsrc    = c_IMM_U;
      end
      c_OP_AUIPC: begin
        w_regwrite  = 1'b1;
        w_alusrc    = 1'b1;
        w_immsrc    = c_IMM_U;
      end
      default: ;
    endcase
  end

  // ----------------------------------------------------------------- extend
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_extimm;

  // Assemble the 32-bit sign-extended immediate for the selected format.
  always_comb begin
    w_imm32 = {{20{instrD[31]}}, instrD[31:20]};
    case (w_immsrc)
      c_IMM_S: w_imm32 = {{20{instrD[31]}}, instrD[31:25], instrD[11:7]};
      c_IMM_B: w_imm32 = {{20{instrD[31]}}, instrD[7], instrD[30:25], instrD[11:8], 1'b0};
      c_IMM_J: w_imm32 = {{12{instrD[31]}}, instrD[19:12], instrD[20], instrD[30:21], 1'b0};
      c_IMM_U: w_imm32 = {instrD[31:12], 12'b0};
      default: ;
    endcase
  end

  generate
    if (XLEN > 32) begin : g_imm_wide
      assign w_extimm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
    end else begin : g_imm_narrow
      assign w_extimm = w_imm32[XLEN-1:0];
    end
  endgenerate

  // ---------------------------------------------------------------- hazards
  logic w_lwstall;
  logic w_take;

  assign w_lwstall = validD & validE & (resultsrcE == 2'b01) & (rdE != '0) &
                     ((w_rs1D == rdE) | (w_rs2D == rdE));
  assign stallFD   = w_lwstall;
  // A real, unflushed, unstalled instruction is captured; anything else is a bubble.
  assign w_take    = validD & ~flushE & ~w_lwstall;

  // ID/EX pipeline register; bubbles clear every field to zero.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      validE      <= 1'b0;
      regwriteE   <= 1'b0;
      memwriteE   <= 1'b0;
      branchE     <= 1'b0;
      jumpE       <= 1'b0;
      jalrE       <= 1'b0;
      alusrcE     <= 1'b0;
      resultsrcE  <= '0;
      alucontrolE <= '0;
      addrmodeE   <= '0;
      rd1E        <= '0;
      rd2E        <= '0;
      extimmE     <= '0;
      pcE         <= '0;
      rs1E        <= '0;
      rs2E        <= '0;
      rdE         <= '0;
    end else begin
      validE      <= w_take;
      regwriteE   <= w_take & w_regwrite;
      memwriteE   <= w_take & w_memwrite;
      branchE     <= w_take & w_branch;
      jumpE       <= w_take & w_jump;
      jalrE       <= w_take & w_jalr;
      alusrcE     <= w_take & w_alusrc;
      resultsrcE  <= w_take ? w_resultsrc : '0;
      alucontrolE <= w_take ? w_aluctl    : '0;
      addrmodeE   <= w_take ? w_addrmode  : '0;
      rd1E        <= w_take ? w_rd1       : '0;
      rd2E        <= w_take ? w_rd2       : '0;
      extimmE     <= w_take ? w_extimm    : '0;
      pcE         <= w_take ? pcD         : '0;
      rs1E        <= w_take ? w_rs1D      : '0;
      rs2E        <= w_take ? w_rs2D      : '0;
      rdE         <= w_take ? w_rdD       : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decode_stage_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_decode_stage_reg                                          |
// | Description : Directed scoreboard bench for decode_stage_reg.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_decode_stage_reg;

  logic        CLK;
  logic        rst_n;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic        validD;
  logic        flushE;
  logic        regwriteW;
  logic [4:0]  rdW;
  logic [31:0] resultW;
  logic        stallFD, validE, regwriteE, memwriteE, branchE, jumpE, jalrE, alusrcE;
  logic [1:0]  resultsrcE;
  logic [3:0]  alucontrolE;
  logic [2:0]  addrmodeE;
  logic [31:0] rd1E, rd2E, extimmE, pcE;
  logic [4:0]  rs1E, rs2E, rdE;

  decode_stage_reg #(.XLEN(32), .NREGS(32)) dut (
    .CLK(CLK), .rst_n(rst_n), .instrD(instrD), .pcD(pcD), .validD(validD),
    .flushE(flushE), .regwriteW(regwriteW), .rdW(rdW), .resultW(resultW),
    .stallFD(stallFD), .validE(validE), .regwriteE(regwriteE), .memwriteE(memwriteE),
    .branchE(branchE), .jumpE(jumpE), .jalrE(jalrE), .alusrcE(alusrcE),
    .resultsrcE(resultsrcE), .alucontrolE(alucontrolE), .addrmodeE(addrmodeE),
    .rd1E(rd1E), .rd2E(rd2E), .extimmE(extimmE), .pcE(pcE),
    .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        valid;
    logic        regwrite;
    logic        memwrite;
    logic [1:0]  resultsrc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    bit          chkimm;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nmis = 0;

  localparam logic [31:0] c_ADD_X6_X5_X0 = 32'h00028333;
  localparam logic [31:0] c_ADDI_X1_X0_7 = 32'h00700093;
  localparam logic [31:0] c_ADDI_X7_M1   = 32'hFFF00393;
  localparam logic [31:0] c_LW_X3_0_X2   = 32'h00012183;
  localparam logic [31:0] c_ADD_X4_X3_X1 = 32'h00118233;
  localparam logic [31:0] c_SW_X1_4_X2   = 32'h00112223;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic exp_t bubble();
    exp_t e;
    e = '{default: 0};
    return e;
  endfunction

  function automatic exp_t mk(input logic rw, input logic mw, input logic [1:0] rs,
                              input logic [31:0] d1, input logic [31:0] d2,
                              input logic [31:0] imm, input bit ci, input logic [31:0] pc,
                              input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
    exp_t e;
    e.valid = 1'b1; e.regwrite = rw; e.memwrite = mw; e.resultsrc = rs;
    e.rd1 = d1; e.rd2 = d2; e.imm = imm; e.chkimm = ci; e.pc = pc;
    e.rs1 = a1; e.rs2 = a2; e.rd = ad;
    return e;
  endfunction

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic vd,
                       input logic fl, input logic we, input logic [4:0] wr,
                       input logic [31:0] wd);
    instrD = ins; pcD = pc; validD = vd; flushE = fl;
    regwriteW = we; rdW = wr; resultW = wd;
  endtask

  // Advance one rising edge, then compare the ID/EX contents with the oldest expectation.
  task automatic tick(input string step);
    exp_t e;
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      nvec++;
      nmis++;
      $error("FAIL %s.scoreboard: observed empty queue, expected an entry", step);
    end else begin
      e = sb.pop_front();
      chk({step, ".validE"},     32'(validE),     32'(e.valid));
      chk({step, ".regwriteE"},  32'(regwriteE),  32'(e.regwrite));
      chk({step, ".memwriteE"},  32'(memwriteE),  32'(e.memwrite));
      chk({step, ".resultsrcE"}, 32'(resultsrcE), 32'(e.resultsrc));
      chk({step, ".rd1E"},       rd1E,            e.rd1);
      chk({step, ".rd2E"},       rd2E,            e.rd2);
      chk({step, ".pcE"},        pcE,             e.pc);
      chk({step, ".rs1E"},       32'(rs1E),       32'(e.rs1));
      chk({step, ".rs2E"},       32'(rs2E),       32'(e.rs2));
      chk({step, ".rdE"},        32'(rdE),        32'(e.rd));
      if (e.chkimm) chk({step, ".extimmE"}, extimmE, e.imm);
    end
  endtask

  // Directed sequence covering reset, W->D forwarding, x0, load-use, flush, async reset.
  initial begin
    rst_n = 1'b0;
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    repeat (3) @(posedge CLK);
    #1 rst_n = 1'b1;
    #1;
    chk("reset.validE",    32'(validE),    32'h0);
    chk("reset.regwriteE", 32'(regwriteE), 32'h0);
    chk("reset.memwriteE", 32'(memwriteE), 32'h0);
    chk("reset.rd1E",      rd1E,           32'h0);
    chk("reset.pcE",       pcE,            32'h0);
    chk("reset.rdE",       32'(rdE),       32'h0);
    chk("reset.stallFD",   32'(stallFD),   32'h0);

    sb.push_back(bubble());
    tick("idle");

    // Same-cycle W write of x5 and D read of x5
    drive(c_ADD_X6_X5_X0, 32'h100, 1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF);
    sb.push_back(mk(1'b1, 1'b0, 2'b00, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 32'h100, 5'd5, 5'd0, 5'd6));
    tick("wd");

    // Attempted write to x0, then read x0
    drive(32'h0, 32'h104, 1'b0, 1'b0, 1'b1, 5'd0, 32'h1234);
    sb.push_back(bubble());
    tick("x0wr");
    drive(c_ADDI_X1_X0_7, 32'h108, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    sb.push_back(mk(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h7, 1'b1, 32'h108, 5'd0, 5'd7, 5'd1));
    tick("addi");

    // Negative immediate; W writes x1 = 0x11 for later use
    drive(c_ADDI_X7_M1, 32'h10C, 1'b1, 1'b0, 1'b1, 5'd1, 32'h11);
    sb.push_back(mk(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b1, 32'h10C, 5'd0, 5'd31, 5'd7));
    tick("addineg");

    // Load-use: lw x3 then add x4,x3,x1 (W writes x2 = 0x40 alongside the lw)
    drive(c_LW_X3_0_X2, 32'h110, 1'b1, 1'b0, 1'b1, 5'd2, 32'h40);
    #1 chk("lw.stallFD", 32'(stallFD), 32'h0);
    sb.push_back(mk(1'b1, 1'b0, 2'b01, 32'h40, 32'h0, 32'h0, 1'b1, 32'h110, 5'd2, 5'd0, 5'd3));
    tick("lw");
    drive(c_ADD_X4_X3_X1, 32'h114, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    #1 chk("lu.stallFD_on", 32'(stallFD), 32'h1);
    sb.push_back(bubble());
    tick("lu_bubble");
    chk("lu.stallFD_off", 32'(stallFD), 32'h0);
    sb.push_back(mk(1'b1, 1'b0, 2'b00, 32'h0, 32'h11, 32'h0, 1'b0, 32'h114, 5'd3, 5'd1, 5'd4));
    tick("lu_add");

    // Flush a store, then let it through
    drive(c_SW_X1_4_X2, 32'h118, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
    sb.push_back(bubble());
    tick("flush");
    drive(c_SW_X1_4_X2, 32'h118, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    sb.push_back(mk(1'b0, 1'b1, 2'b00, 32'h40, 32'h11, 32'h4, 1'b1, 32'h118, 5'd2, 5'd1, 5'd4));
    tick("sw");

    // Flush coinciding with a load-use stall yields a single bubble
    drive(c_LW_X3_0_X2, 32'h11C, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    sb.push_back(mk(1'b1, 1'b0, 2'b01, 32'h40, 32'h0, 32'h0, 1'b1, 32'h11C, 5'd2, 5'd0, 5'd3));
    tick("lw2");
    drive(c_ADD_X4_X3_X1, 32'h120, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
    #1 chk("flu.stallFD_on", 32'(stallFD), 32'h1);
    sb.push_back(bubble());
    tick("flush_lu");
    drive(c_ADD_X4_X3_X1, 32'h120, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    #1 chk("flu.stallFD_off", 32'(stallFD), 32'h0);
    sb.push_back(mk(1'b1, 1'b0, 2'b00, 32'h0, 32'h11, 32'h0, 1'b0, 32'h120, 5'd3, 5'd1, 5'd4));
    tick("lu_add2");

    // Asynchronous reset between clock edges while E holds a real instruction
    #2 rst_n = 1'b0;
    #1;
    chk("areset.validE",    32'(validE),    32'h0);
    chk("areset.regwriteE", 32'(regwriteE), 32'h0);
    chk("areset.rd2E",      rd2E,           32'h0);
    chk("areset.pcE",       pcE,            32'h0);
    chk("areset.stallFD",   32'(stallFD),   32'h0);
    #3 rst_n = 1'b1;
    drive(c_ADD_X6_X5_X0, 32'h124, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    sb.push_back(mk(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 32'h124, 5'd5, 5'd0, 5'd6));
    tick("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
`default_nettype wire
